noise_stats_monitor: RTL
========================

# noise_stats_monitor

Downstream measurement stage for the noisy amplifier model. Samples the amplifier's noisy real-valued output once per clock over a fixed window and reports sample mean, population variance and a count of samples above a slicer threshold. Used by SerDes flicker-noise benches to check noise statistics in-simulation, without post-processing. Simulation only: uses `real` arithmetic.

## Interface
Parameters:
- WINDOW, 1024: samples per measurement; elaboration error if < 2.
- THRESHOLD, 5.0 (real): slicer level in V; a sample counts as above only if strictly greater.
- COUNT_W, 16: width of above_cnt; elaboration error if $clog2(WINDOW+1) > COUNT_W.

Ports:
- clk  in  1  sample clock, same as the amplifier's.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a measurement; honoured only in IDLE.
- sample_in  in  real  amplifier output with noise (V).
- busy  out  1  high in ACCUM and CALC.
- done  out  1  one-cycle pulse when results update.
- mean_out  out  real  window mean (V).
- var_out  out  real  window population variance (V²), never negative.
- above_cnt  out  COUNT_W  samples > THRESHOLD in the window.
- min_out, max_out  out  real  window extrema; present only with NOISE_MON_PEAK_EN.

## Operation
- FSM states: IDLE, ACCUM, CALC.
- IDLE: start=1 → ACCUM. Clear sum, sum_sq, above, and sample count n. start=0 → stay.
- ACCUM: each cycle add sample_in to sum, sample_in² to sum_sq. Increment above if sample_in > THRESHOLD. Increment n. When n reaches WINDOW (the last sample is included) → CALC.
- CALC: mean = sum/WINDOW; var = sum_sq/WINDOW − mean². If var < 0.0 (rounding), force var to 0.0. Register mean_out, var_out, above_cnt; pulse done; → IDLE.
- start during ACCUM/CALC is ignored; no queuing.
- start in the same cycle that CALC returns to IDLE is ignored, because the FSM is not yet in IDLE.
- Outputs hold their values until the next done.
- NaN or inf on sample_in propagates into the results; it is not checked.
- Reset, at any time including mid-window: FSM → IDLE; accumulators, n, and all outputs cleared.

## Timing
- Reset values: busy=0, done=0, mean_out=0.0, var_out=0.0, above_cnt=0, min_out=0.0, max_out=0.0.
- start sampled high at edge t (IDLE) → busy=1 after edge t.
- sample_in is captured at edges t+1 … t+WINDOW.
- At edge t+WINDOW+1 (CALC): results update, done=1 for that one cycle, busy=0.
- Start-to-done latency: WINDOW+1 cycles. Back-to-back throughput: one measurement per WINDOW+2 cycles.
- Counters wrap-free by construction: n counts to WINDOW exactly; above ≤ WINDOW fits in COUNT_W.

## Configuration
- NOISE_MON_PEAK_EN defined:
  - Track running min/max over the window. First sample in the window initialises both.
  - min_out/max_out are updated at done alongside the other results.
- NOISE_MON_PEAK_EN undefined:
  - min_out/max_out ports and the tracking logic are absent.
  - All other behaviour is identical.

## Structure
- Package noise_mon_pkg:
  - state enum typedef (IDLE, ACCUM, CALC).
  - default constants DEF_WINDOW=1024, DEF_THRESHOLD=5.0.
- Sub-module noise_accum holds sum, sum_sq, above counter and optional min/max, with clear/enable inputs. The top holds the FSM, n counter and the final divide/clamp.

## Test plan
- WINDOW=4, constant 5.0, start pulse → done at start+5 cycles, mean 5.0, var 0.0, above_cnt 0 (5.0 is not > 5.0).
- WINDOW=4, samples 4.0,6.0,4.0,6.0 → mean 5.0, var 1.0, above_cnt 2. With NOISE_MON_PEAK_EN: min 4.0, max 6.0.
- start held high for the whole run → measurements repeat every 6 cycles (WINDOW=4). Extra start pulses while busy produce no extra done.
- rst asserted two samples into a window → all outputs 0 immediately, busy=0, no done. A fresh start → correct results from new samples only.
- Samples 1e6+0.001, 1e6−0.001 alternating → var ≥ 0.0, never negative.
- Amplifier chain GAIN=10, input 0.5 V, WINDOW=1024 → mean within 5.0±0.1, var > 0.0, done pulse exactly 1 cycle wide.

Source files
------------

// File: rtl/noise_mon_pkg.sv
// ============================================================================
// noise_mon_pkg : shared state encoding and default constants for the monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package noise_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      CALC  = 2'd2
   } state_t;

   localparam int  DEF_WINDOW    = 1024;
   localparam real DEF_THRESHOLD = 5.0;

endpackage

`default_nettype wire

// File: rtl/noise_accum.sv
// ============================================================================
// noise_accum : running sum, sum of squares, above-threshold count and
//               (with NOISE_MON_PEAK_EN) window min/max. Simulation-only reals.
// Rev 1.0
// ============================================================================
`default_nettype none

module noise_accum
   import noise_mon_pkg::*;
#(
   parameter real THRESHOLD = DEF_THRESHOLD,
   parameter int  COUNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_en,
   input  real                i_sample,
   output real                o_sum,
   output real                o_sum_sq,
   output logic [COUNT_W-1:0] o_above
`ifdef NOISE_MON_PEAK_EN
   ,
   output real                o_min,
   output real                o_max
`endif
);

   real                r_sum;
   real                r_sum_sq;
   logic [COUNT_W-1:0] r_above;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum    <= 0.0;
         r_sum_sq <= 0.0;
         r_above  <= '0;
      end else if (i_clr) begin
         r_sum    <= 0.0;
         r_sum_sq <= 0.0;
         r_above  <= '0;
      end else if (i_en) begin
         r_sum    <= r_sum + i_sample;
         r_sum_sq <= r_sum_sq + i_sample * i_sample;
         if (i_sample > THRESHOLD) begin
            r_above <= r_above + COUNT_W'(1);
         end
      end
   end

   assign o_sum    = r_sum;
   assign o_sum_sq = r_sum_sq;
   assign o_above  = r_above;

`ifdef NOISE_MON_PEAK_EN
   real  r_min;
   real  r_max;
   logic r_seen;

   // r_seen lets the first sample of a window seed both extrema.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_min  <= 0.0;
         r_max  <= 0.0;
         r_seen <= 1'b0;
      end else if (i_clr) begin
         r_min  <= 0.0;
         r_max  <= 0.0;
         r_seen <= 1'b0;
      end else if (i_en) begin
         r_seen <= 1'b1;
         if (!r_seen || (i_sample < r_min)) begin
            r_min <= i_sample;
         end
         if (!r_seen || (i_sample > r_max)) begin
            r_max <= i_sample;
         end
      end
   end

   assign o_min = r_min;
   assign o_max = r_max;
`endif

endmodule

`default_nettype wire

// File: rtl/noise_stats_monitor.sv
// ============================================================================
// noise_stats_monitor : windowed mean / population variance / slicer count of
//                       a real-valued sample stream. Optional NOISE_MON_PEAK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module noise_stats_monitor
   import noise_mon_pkg::*;
#(
   parameter int  WINDOW    = DEF_WINDOW,
   parameter real THRESHOLD = DEF_THRESHOLD,
   parameter int  COUNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  real                sample_in,
   output logic               busy,
   output logic               done,
   output real                mean_out,
   output real                var_out,
   output logic [COUNT_W-1:0] above_cnt
`ifdef NOISE_MON_PEAK_EN
   ,
   output real                min_out,
   output real                max_out
`endif
);

   localparam int c_N_W = $clog2(WINDOW + 1);

   if (WINDOW < 2) begin : g_bad_window
      $error("noise_stats_monitor: WINDOW must be at least 2");
   end
   if (c_N_W > COUNT_W) begin : g_bad_count_w
      $error("noise_stats_monitor: COUNT_W too narrow for WINDOW");
   end

   state_t             r_state;
   state_t             w_next;
   logic [c_N_W-1:0]   r_n;
   logic               w_clr;
   logic               w_en;
   logic               w_last;
   real                w_sum;
   real                w_sum_sq;
   real                w_mean;
   real                w_var_raw;
   real                w_var;
   logic [COUNT_W-1:0] w_above;
`ifdef NOISE_MON_PEAK_EN
   real                w_min;
   real                w_max;
`endif

   noise_accum #(
      .THRESHOLD (THRESHOLD),
      .COUNT_W   (COUNT_W)
   ) u_accum (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_en     (w_en),
      .i_sample (sample_in),
      .o_sum    (w_sum),
      .o_sum_sq (w_sum_sq),
      .o_above  (w_above)
`ifdef NOISE_MON_PEAK_EN
      ,
      .o_min    (w_min),
      .o_max    (w_max)
`endif
   );

   // The edge that captures sample WINDOW also moves the FSM into CALC.
   assign w_last = (r_n == c_N_W'(WINDOW - 1));

   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_en   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_clr  = 1'b1;
               w_next = ACCUM;
            end
         end
         ACCUM: begin
            w_en = 1'b1;
            if (w_last) begin
               w_next = CALC;
            end
         end
         CALC:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_n     <= '0;
      end else begin
         r_state <= w_next;
         if (w_clr) begin
            r_n <= '0;
         end else if (w_en) begin
            r_n <= r_n + c_N_W'(1);
         end
      end
   end

   // Rounding can push E[x^2]-mean^2 slightly negative; NaN fails the test and passes through.
   always_comb begin
      w_mean    = w_sum / real'(WINDOW);
      w_var_raw = w_sum_sq / real'(WINDOW) - w_mean * w_mean;
      w_var     = (w_var_raw < 0.0) ? 0.0 : w_var_raw;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done      <= 1'b0;
         mean_out  <= 0.0;
         var_out   <= 0.0;
         above_cnt <= '0;
`ifdef NOISE_MON_PEAK_EN
         min_out   <= 0.0;
         max_out   <= 0.0;
`endif
      end else begin
         done <= (r_state == CALC);
         if (r_state == CALC) begin
            mean_out  <= w_mean;
            var_out   <= w_var;
            above_cnt <= w_above;
`ifdef NOISE_MON_PEAK_EN
            min_out   <= w_min;
            max_out   <= w_max;
`endif
         end
      end
   end

   assign busy = (r_state != IDLE);

endmodule

`default_nettype wire
